// File: rtl/mux_sel_serializer.sv
// rtl/mux_sel_serializer.sv - parallel word to 8:1 mux select walker with frame markers
module mux_sel_serializer #(
    parameter int WIDTH     = 8,
    parameter int SEL_W     = 3,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic [SEL_W-1:0] sel,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_done
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    // First and last select index of a word, depending on walk direction
    localparam logic [SEL_W-1:0] START = (MSB_FIRST != 0) ? SEL_W'(WIDTH - 1) : '0;
    localparam logic [SEL_W-1:0] LAST  = (MSB_FIRST != 0) ? '0 : SEL_W'(WIDTH - 1);

    logic [0:0]       state;
    logic [WIDTH-1:0] word_q;
    logic [SEL_W-1:0] sel_q;
    logic             accept;

    // Output decodes of registered state; ready also opens on the last bit
    // so a new word can follow with no bubble, and stays shut during reset
    always_comb begin
        ser_valid   = (state == S_SHIFT);
        ser_out     = ser_valid ? word_q[sel_q] : 1'b0;
        frame_start = ser_valid && (sel_q == START);
        frame_done  = ser_valid && (sel_q == LAST);
        load_ready  = !rst && ((state == S_IDLE) || frame_done);
        accept      = load_valid && load_ready;
        sel         = sel_q;
    end

    // Word capture, select stepping and IDLE/SHIFT sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            word_q <= '0;
            sel_q  <= START;
        end else if (accept) begin
            state  <= S_SHIFT;
            word_q <= load_data;
            sel_q  <= START;
        end else if (state == S_SHIFT) begin
            if (frame_done) begin
                state <= S_IDLE;
                sel_q <= START;
            end else if (MSB_FIRST != 0) begin
                sel_q <= sel_q - SEL_W'(1);
            end else begin
                sel_q <= sel_q + SEL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mux_sel_serializer.sv
// tb/tb_mux_sel_serializer.sv - scoreboard bench, LSB-first and MSB-first instances in lockstep
module tb_mux_sel_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic [7:0] load_data;

    logic       load_ready0, ser_out0, ser_valid0, frame_start0, frame_done0;
    logic [2:0] sel0;
    logic       load_ready1, ser_out1, ser_valid1, frame_start1, frame_done1;
    logic [2:0] sel1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [7:0] d;
        int         k;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    mux_sel_serializer #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(0)) u0 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready0),
        .load_data(load_data), .sel(sel0), .ser_out(ser_out0), .ser_valid(ser_valid0),
        .frame_start(frame_start0), .frame_done(frame_done0)
    );

    mux_sel_serializer #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1)) u1 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready1),
        .load_data(load_data), .sel(sel1), .ser_out(ser_out1), .ser_valid(ser_valid1),
        .frame_start(frame_start1), .frame_done(frame_done1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference 8:1 mux: D0..D7 from the word, S2..S0 from sel
    function automatic logic mux_81(input logic [7:0] d, input logic [2:0] s);
        logic [7:0] dd;
        dd = d;
        return dd[s];
    endfunction

    // Monitor: pop and compare every cycle either DUT presents a bit
    initial begin
        exp_t e;
        logic prev_valid;
        logic exp_ready;
        int   s0, s1;
        prev_valid = 1'b0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("valid_lockstep", ser_valid1, ser_valid0);
            if (ser_valid0 === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_bit", 1, 0);
                end else begin
                    e  = q.pop_front();
                    s0 = e.k;
                    s1 = 7 - e.k;
                    exp_ready = rst ? 1'b0 : (e.k == 7);
                    chk("sel_lsb", sel0, s0);
                    chk("out_lsb", ser_out0, e.d[s0]);
                    chk("fs_lsb", frame_start0, e.k == 0);
                    chk("fd_lsb", frame_done0, e.k == 7);
                    chk("sel_msb", sel1, s1);
                    chk("out_msb", ser_out1, e.d[s1]);
                    chk("fs_msb", frame_start1, e.k == 0);
                    chk("fd_msb", frame_done1, e.k == 7);
                    chk("mux_e2e_lsb", ser_out0, mux_81(e.d, sel0));
                    chk("mux_e2e_msb", ser_out1, mux_81(e.d, sel1));
                    if (e.k != 0) chk("no_gap", prev_valid, 1'b1);
                    chk("ready_lsb", load_ready0, exp_ready);
                    chk("ready_msb", load_ready1, exp_ready);
                end
            end else begin
                exp_ready = !rst;
                chk("idle_fs", frame_start0 | frame_start1, 0);
                chk("idle_fd", frame_done0 | frame_done1, 0);
                chk("idle_out", ser_out0 | ser_out1, 0);
                chk("idle_sel_lsb", sel0, 3'd0);
                chk("idle_sel_msb", sel1, 3'd7);
                chk("idle_ready_lsb", load_ready0, exp_ready);
                chk("idle_ready_msb", load_ready1, exp_ready);
            end
            prev_valid = ser_valid0;
        end
    end

    // Present a word, wait for the handshake, queue its expected bits
    task automatic send(input logic [7:0] d, input bit keep, output int edges);
        logic r;
        edges = 0;
        load_data  = d;
        load_valid = 1'b1;
        do begin
            @(negedge clk);
            r = load_ready0;
            @(posedge clk);
            edges++;
        end while (!r && edges < 50);
        if (!r) chk("accept_timeout", 0, 1);
        for (int k = 0; k < 8; k++) begin
            exp_t e;
            e.d = d;
            e.k = k;
            q.push_back(e);
        end
        #1;
        if (!keep) load_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'hAA;

        // Reset held with a word offered
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", load_ready0, 0);
        chk("rst_valid", ser_valid0, 0);
        chk("rst_sel", sel0, 0);
        load_valid = 1'b0;
        rst        = 1'b0;
        #1;
        chk("post_rst_ready", load_ready0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle", ser_valid0, 0);

        // Single word
        send(8'hA5, 1'b0, n);
        chk("single_first_valid", ser_valid0, 1);
        chk("single_first_fs", frame_start0, 1);
        repeat (8) @(posedge clk);
        #1;
        chk("single_back_idle", ser_valid0, 0);

        // Back-to-back with load_valid held
        send(8'hFF, 1'b1, n);
        send(8'h00, 1'b0, n);
        chk("b2b_accept_edges", n, 8);
        chk("b2b_adjacent_valid", ser_valid0, 1);
        chk("b2b_adjacent_fs", frame_start0, 1);
        repeat (9) @(posedge clk);
        #1;

        // Backpressure mid-word
        send(8'h11, 1'b0, n);
        repeat (3) @(posedge clk);
        #1;
        send(8'h3C, 1'b0, n);
        chk("bp_wait_edges", n, 5);
        repeat (9) @(posedge clk);
        #1;

        // Reset during bit 4
        send(8'h0F, 1'b0, n);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_valid", ser_valid0, 0);
        chk("midrst_sel", sel0, 0);
        chk("midrst_fd", frame_done0, 0);
        chk("midrst_pending", q.size(), 3);
        q.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(8'h81, 1'b0, n);
        repeat (9) @(posedge clk);
        #1;

        // Single set bit, exercises the MSB-first end marker at sel=0
        send(8'h01, 1'b0, n);
        for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        chk("drained", q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
